rtc_bus_arbiter: RTL and testbench

- Shares the single multiplexed AD bus to the RTC chip (ad, wr, rd, cs, 8-bit address/data) between three transaction sequencers.
  - Requester 0: time-set writer.
  - Requester 1: chrono-set writer.
  - Requester 2: periodic time reader.
- Grants one sequencer at a time with round-robin priority and muxes its bus drive onto the pads.
- Enforces idle guard gaps between owners and a per-grant timeout.
- Schedules the periodic refresh read request.

---
 rtl/rtc_bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_rtc_bus_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_arbiter.sv
// Round-robin owner of the shared RTC AD bus: three sequencers, idle guard gaps,
// per-grant timeout and a free-running periodic refresh request for the reader.
module rtc_bus_arbiter #(
   parameter int REFRESH_CYCLES = 1000000,
   parameter int GUARD_CYCLES   = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [2:0]  req,
   input  logic [2:0]  done,
   input  logic [2:0]  m_ad,
   input  logic [2:0]  m_wr,
   input  logic [2:0]  m_rd,
   input  logic [2:0]  m_cs,
   input  logic [23:0] m_dout,
   input  logic [2:0]  m_doe,
   output logic [2:0]  gnt,
   output logic        refresh_req,
   output logic        bus_ad,
   output logic        bus_wr,
   output logic        bus_rd,
   output logic        bus_cs,
   output logic [7:0]  bus_dout,
   output logic        bus_doe,
   output logic        busy,
   output logic        timeout_err
);

   localparam int RW   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam int TMAX = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] GD_LAST  = TW'(GUARD_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GUARD} state_t;

   state_t          state_q, state_d;
   logic [2:0]      gnt_q, gnt_d;
   logic [1:0]      last_q, last_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic [RW-1:0]   ref_cnt_q, ref_cnt_d;
   logic            refresh_q, refresh_d;
   logic            terr_q, terr_d;
   logic [1:0]      owner;

   // First requester found scanning last+1, last+2, last (mod 3).
   function automatic logic [1:0] next_owner(input logic [1:0] last, input logic [2:0] r);
      logic [1:0] pick;
      logic [1:0] idx;
      pick = last;
      for (int k = 3; k >= 1; k--) begin
         idx = 2'((int'(last) + k) % 3);
         if (r[idx]) pick = idx;
      end
      return pick;
   endfunction

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      last_d    = last_q;
      tmr_d     = tmr_q;
      terr_d    = 1'b0;
      refresh_d = refresh_q;
      owner     = last_q;
      ref_cnt_d = (ref_cnt_q == REF_LAST) ? '0 : ref_cnt_q + RW'(1);

      case (state_q)
         S_IDLE: begin
            if (|req) begin
               owner   = next_owner(last_q, req);
               gnt_d   = 3'b001 << owner;
               last_d  = owner;
               tmr_d   = '0;
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            // A normal release wins over a coincident timeout.
            if ((|(gnt_q & done)) || !(|(gnt_q & req))) begin
               gnt_d   = 3'b000;
               tmr_d   = '0;
               state_d = S_GUARD;
            end else if (tmr_q == TO_LAST) begin
               gnt_d   = 3'b000;
               tmr_d   = '0;
               terr_d  = 1'b1;
               state_d = S_GUARD;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         S_GUARD: begin
            if (tmr_q == GD_LAST) state_d = S_IDLE;
            else                  tmr_d   = tmr_q + TW'(1);
         end
         default: state_d = S_IDLE;
      endcase

      // A wrap re-arms the request even if it coincides with the clearing grant.
      if (gnt_d[2] && !gnt_q[2]) refresh_d = 1'b0;
      if (ref_cnt_q == REF_LAST) refresh_d = 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         gnt_q     <= 3'b000;
         last_q    <= 2'd2;
         tmr_q     <= '0;
         ref_cnt_q <= '0;
         refresh_q <= 1'b0;
         terr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         last_q    <= last_d;
         tmr_q     <= tmr_d;
         ref_cnt_q <= ref_cnt_d;
         refresh_q <= refresh_d;
         terr_q    <= terr_d;
      end
   end

   // Pads follow the registered grant so an async reset idles the bus at once.
   always_comb begin
      bus_ad   = 1'b1;
      bus_wr   = 1'b1;
      bus_rd   = 1'b1;
      bus_cs   = 1'b1;
      bus_dout = 8'h00;
      bus_doe  = 1'b0;
      if (gnt_q[0]) begin
         bus_ad = m_ad[0]; bus_wr = m_wr[0]; bus_rd = m_rd[0]; bus_cs = m_cs[0];
         bus_dout = m_dout[7:0];   bus_doe = m_doe[0];
      end else if (gnt_q[1]) begin
         bus_ad = m_ad[1]; bus_wr = m_wr[1]; bus_rd = m_rd[1]; bus_cs = m_cs[1];
         bus_dout = m_dout[15:8];  bus_doe = m_doe[1];
      end else if (gnt_q[2]) begin
         bus_ad = m_ad[2]; bus_wr = m_wr[2]; bus_rd = m_rd[2]; bus_cs = m_cs[2];
         bus_dout = m_dout[23:16]; bus_doe = m_doe[2];
      end
   end

   assign gnt         = gnt_q;
   assign refresh_req = refresh_q;
   assign busy        = (state_q != S_IDLE);
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Bench for rtc_bus_arbiter: grant scoreboard plus directed checks of guard
// gaps, timeout, refresh scheduling and asynchronous reset.
module tb_rtc_bus_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [2:0]  req = '0, done = '0;
   logic [2:0]  m_ad = 3'b101, m_wr = 3'b011, m_rd = 3'b110, m_cs = 3'b000, m_doe = 3'b101;
   logic [23:0] m_dout = 24'hC35AA5;
   logic [2:0]  gnt;
   logic        refresh_req, bus_ad, bus_wr, bus_rd, bus_cs, bus_doe, busy, timeout_err;
   logic [7:0]  bus_dout;

   int n_checks = 0;
   int n_errors = 0;
   int q_exp[$];
   logic [2:0] prev_gnt = '0;

   rtc_bus_arbiter #(.REFRESH_CYCLES(16), .GUARD_CYCLES(4), .TIMEOUT_CYCLES(8)) dut (
      .clock(clock), .reset(reset), .req(req), .done(done),
      .m_ad(m_ad), .m_wr(m_wr), .m_rd(m_rd), .m_cs(m_cs), .m_dout(m_dout), .m_doe(m_doe),
      .gnt(gnt), .refresh_req(refresh_req), .bus_ad(bus_ad), .bus_wr(bus_wr),
      .bus_rd(bus_rd), .bus_cs(bus_cs), .bus_dout(bus_dout), .bus_doe(bus_doe),
      .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Expected pad vector {ad,wr,rd,cs,doe,dout} when requester i owns the bus.
   function automatic logic [12:0] exp_bus(input int i);
      return {m_ad[i], m_wr[i], m_rd[i], m_cs[i], m_doe[i], m_dout[8*i +: 8]};
   endfunction

   // Scoreboard: each new grant pops the owner that the stimulus predicted.
   always @(negedge clock) begin
      if (!reset) begin
         prev_gnt = '0;
      end else begin
         if (gnt != 3'b000 && prev_gnt == 3'b000) begin
            if (q_exp.size() == 0) begin
               chk("sb_unexpected_grant", {29'd0, gnt}, 32'd0);
            end else begin
               int idx;
               idx = q_exp.pop_front();
               chk("sb_gnt", {29'd0, gnt}, 32'd1 << idx);
               chk("sb_bus", {19'd0, bus_ad, bus_wr, bus_rd, bus_cs, bus_doe, bus_dout},
                   {19'd0, exp_bus(idx)});
            end
         end
         prev_gnt = gnt;
      end
   end

   // Ticks until a grant appears; returns the number of ticks taken.
   task automatic wait_grant(output int n);
      n = 0;
      while (gnt == 3'b000 && n < 40) begin
         tick();
         n++;
      end
      if (gnt == 3'b000) chk("grant_wait_expired", 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      #2 reset = 1'b0;
      tick(2);
      @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin
      int gap;
      logic [2:0] g;

      // Reset values
      tick(3);
      chk("rst_gnt", {29'd0, gnt}, 32'd0);
      chk("rst_flags", {28'd0, busy, timeout_err, refresh_req, bus_doe}, 32'd0);
      chk("rst_bus", {28'd0, bus_ad, bus_wr, bus_rd, bus_cs}, 32'hF);
      chk("rst_dout", {24'd0, bus_dout}, 32'd0);

      // Refresh scheduling, aligned to reset release
      @(negedge clock);
      reset = 1'b1;
      tick(15);
      chk("ref_before_wrap", {31'd0, refresh_req}, 32'd0);
      tick();
      chk("ref_at_wrap", {31'd0, refresh_req}, 32'd1);
      tick(3);
      req = 3'b100; q_exp.push_back(2);
      tick();
      chk("ref_grant2", {29'd0, gnt}, 32'b100);
      chk("ref_cleared", {31'd0, refresh_req}, 32'd0);
      tick(2);
      done = 3'b100;
      tick();
      done = 3'b000; req = 3'b000;
      chk("ref_release", {29'd0, gnt}, 32'd0);
      tick(27);
      chk("ref_no_stack", {31'd0, refresh_req}, 32'd1);
      req = 3'b100; q_exp.push_back(2);
      tick();
      chk("ref_grant2_again", {29'd0, gnt}, 32'b100);
      tick();
      chk("ref_cleared_once", {31'd0, refresh_req}, 32'd0);
      done = 3'b100;
      tick();
      done = 3'b000; req = 3'b000;
      tick(5);

      // Single request, with done pulses on other lines ignored
      do_reset();
      tick(2);
      req = 3'b001; q_exp.push_back(0);
      tick();
      chk("single_gnt", {29'd0, gnt}, 32'b001);
      chk("single_busy", {31'd0, busy}, 32'd1);
      done = 3'b110;
      tick();
      done = 3'b000;
      chk("single_ignore_other_done", {29'd0, gnt}, 32'b001);
      tick(3);
      done = 3'b001;
      tick();
      done = 3'b000; req = 3'b000;
      chk("single_release", {29'd0, gnt}, 32'd0);
      chk("single_guard_bus", {30'd0, bus_cs, bus_doe}, 32'b10);
      chk("single_no_terr", {31'd0, timeout_err}, 32'd0);
      tick(3);
      chk("single_guard_busy", {31'd0, busy}, 32'd1);
      tick();
      chk("single_idle", {31'd0, busy}, 32'd0);

      // Round robin with all three requesting
      do_reset();
      tick();
      req = 3'b111;
      q_exp.push_back(0); q_exp.push_back(1); q_exp.push_back(2); q_exp.push_back(0);
      for (int i = 0; i < 4; i++) begin
         wait_grant(gap);
         if (i > 0) chk("rr_gap", gap, 32'd5);
         g = gnt;
         tick(4);
         done = g;
         tick();
         done = 3'b000;
         chk("rr_release", {29'd0, gnt}, 32'd0);
      end
      req = 3'b000;
      tick(6);

      // Timeout on requester 1, then re-grant while still requesting
      req = 3'b010; q_exp.push_back(1);
      wait_grant(gap);
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("to_hold", {28'd0, gnt, timeout_err}, 32'b0100);
      end
      q_exp.push_back(1);
      tick();
      chk("to_release", {29'd0, gnt}, 32'd0);
      chk("to_err_pulse", {31'd0, timeout_err}, 32'd1);
      tick();
      chk("to_err_single", {31'd0, timeout_err}, 32'd0);
      wait_grant(gap);
      chk("to_regrant_gap", gap, 32'd4);

      // done coincident with the timeout cycle is a normal release
      tick(7);
      done = 3'b010;
      tick();
      done = 3'b000; req = 3'b000;
      chk("dto_release", {29'd0, gnt}, 32'd0);
      chk("dto_no_err", {31'd0, timeout_err}, 32'd0);
      tick(6);

      // Asynchronous reset in the middle of a grant
      req = 3'b010; q_exp.push_back(1);
      wait_grant(gap);
      tick(2);
      #2 reset = 1'b0;
      #1;
      chk("arst_gnt", {29'd0, gnt}, 32'd0);
      chk("arst_bus", {29'd0, bus_cs, bus_doe, busy}, 32'b100);
      req = 3'b011; q_exp.push_back(0);
      tick();
      @(negedge clock);
      reset = 1'b1;
      wait_grant(gap);
      chk("arst_first_gnt", {29'd0, gnt}, 32'b001);
      done = 3'b001;
      tick();
      done = 3'b000; req = 3'b000;
      tick(6);

      chk("sb_drained", q_exp.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
